// File: rtl/nibble_serial_sub32.sv
// nibble_serial_sub32: 32-bit subtractor that processes one nibble per cycle.
// A start in IDLE latches the operands, eight RUN cycles ripple the borrow
// through nibbles 0..7, and FIN publishes the registered result with a
// one-cycle done pulse. Start-to-done is ten cycles; throughput is ten cycles.
module nibble_serial_sub32 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        bin,
    output logic [31:0] diff,
    output logic        bout,
    output logic        ovf,
    output logic        zero,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [31:0] a_reg;
    logic [31:0] b_reg;
    logic [31:0] res_reg;
    logic        borrow;
    logic [2:0]  cnt;

    logic [4:0]  bit_base;
    logic [3:0]  a_nib;
    logic [3:0]  b_nib;
    logic [4:0]  nib_diff;

    // Current nibble slice and its 4-bit subtraction with borrow. The fifth
    // bit of the result is the borrow out of this nibble; when a_nib equals
    // b_nib it simply reproduces the incoming borrow (bypass case).
    assign bit_base = {cnt, 2'b00};
    assign a_nib    = a_reg[bit_base +: 4];
    assign b_nib    = b_reg[bit_base +: 4];
    assign nib_diff = {1'b0, a_nib} - {1'b0, b_nib} - {4'b0000, borrow};

    // State register.
    // NOTE: all clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: start is only honoured in IDLE.
    // NOTE: state_next gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (cnt == 3'd7) state_next = FIN;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode: busy for every non-IDLE state.
    always_comb begin
        busy = (state != IDLE);
    end

    // Working datapath: latch operands on accept, one nibble per RUN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg   <= '0;
            b_reg   <= '0;
            res_reg <= '0;
            borrow  <= 1'b0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg   <= a;
                        b_reg   <= b;
                        borrow  <= bin;
                        res_reg <= '0;
                        cnt     <= '0;
                    end
                end
                RUN: begin
                    res_reg[bit_base +: 4] <= nib_diff[3:0];
                    borrow                 <= nib_diff[4];
                    cnt                    <= cnt + 3'd1;
                end
                default: ;
            endcase
        end
    end

    // Result registers: loaded only from FIN, held otherwise; done pulses once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            diff <= '0;
            bout <= 1'b0;
            ovf  <= 1'b0;
            zero <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == FIN) begin
                diff <= res_reg;
                bout <= borrow;
                ovf  <= (a_reg[31] != b_reg[31]) && (res_reg[31] != a_reg[31]);
                zero <= (res_reg == 32'd0);
                done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_nibble_serial_sub32.sv
// Directed testbench for nibble_serial_sub32. Outputs are sampled on the
// falling clock edge; inputs are driven there as well.
module tb_nibble_serial_sub32;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        bin;
    logic [31:0] diff;
    logic        bout;
    logic        ovf;
    logic        zero;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;

    nibble_serial_sub32 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .diff  (diff),
        .bout  (bout),
        .ovf   (ovf),
        .zero  (zero),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Drives one start in the current (IDLE) cycle and returns at the falling
    // edge where done is first seen. lat counts falling edges from the start
    // cycle (0) to the done cycle; -1 means done never arrived.
    task automatic run_op(input logic [31:0] av, input logic [31:0] bv,
                          input logic binv, output int lat);
        logic [31:0] prev_diff;
        prev_diff = diff;
        a     = av;
        b     = bv;
        bin   = binv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a     = 32'hDEAD_BEEF;
        b     = 32'h0BAD_F00D;
        bin   = 1'b1;
        lat   = 1;
        check("busy_after_accept", {31'd0, busy}, 32'd1);
        while (!done && lat < 20) begin
            if (lat == 5) check("diff_hold_in_run", diff, prev_diff);
            @(negedge clk);
            lat++;
        end
        if (!done) lat = -1;
    endtask

    task automatic op_check(input string tag, input logic [31:0] av,
                            input logic [31:0] bv, input logic binv,
                            input logic [31:0] exp_diff, input logic exp_bout,
                            input logic exp_ovf, input logic exp_zero);
        int lat;
        run_op(av, bv, binv, lat);
        check({tag, "_latency"}, lat, 32'd10);
        check({tag, "_diff"}, diff, exp_diff);
        check({tag, "_bout"}, {31'd0, bout}, {31'd0, exp_bout});
        check({tag, "_ovf"},  {31'd0, ovf},  {31'd0, exp_ovf});
        check({tag, "_zero"}, {31'd0, zero}, {31'd0, exp_zero});
        check({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int lat;
        int done_cnt;
        int first_done;
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        bin   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_diff", diff, 32'd0);
        check("rst_flags", {28'd0, bout, ovf, zero, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic, wrap, signed overflow and bypass-chain vectors.
        op_check("sub5_3", 32'd5, 32'd3, 1'b0, 32'h0000_0002, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("done_one_cycle", {31'd0, done}, 32'd0);
        op_check("sub0_1", 32'd0, 32'd1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        op_check("ovf_min", 32'h8000_0000, 32'd1, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
        op_check("eq_zero", 32'h1234_5678, 32'h1234_5678, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        op_check("eq_bin", 32'h1234_5678, 32'h1234_5678, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        op_check("ovf_pos", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1, 1'b1, 1'b0);
        // Back-to-back: the call above returned in the done cycle (IDLE).
        op_check("b2b_mix", 32'hA5A5_0000, 32'h0000_0001, 1'b1, 32'hA5A4_FFFE, 1'b0, 1'b0, 1'b0);
        @(negedge clk);

        // Start pulsed again at RUN cycle 3 must be ignored.
        a = 32'd100; b = 32'd1; bin = 1'b0; start = 1'b1;
        done_cnt   = 0;
        first_done = -1;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (i == 3) begin
                a = 32'd0; b = 32'd0; bin = 1'b0; start = 1'b1;
            end
            if (done) begin
                done_cnt++;
                if (first_done < 0) begin
                    first_done = i;
                    check("ign_diff", diff, 32'd99);
                end
            end
        end
        start = 1'b0;
        check("ign_done_count", done_cnt, 32'd1);
        check("ign_latency", first_done, 32'd10);
        check("ign_diff_after", diff, 32'd99);

        // Reset at RUN cycle 4 aborts the operation.
        a = 32'd50; b = 32'd7; bin = 1'b0; start = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        check("abort_diff", diff, 32'd0);
        check("abort_flags", {28'd0, bout, ovf, zero, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n    = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("abort_no_done", done_cnt, 32'd0);
        check("abort_idle", {31'd0, busy}, 32'd0);

        // Start accepted in the first cycle after reset release.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        op_check("post_rst", 32'd9, 32'd4, 1'b0, 32'd5, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
